config_commit_scheduler: RTL and testbench

- Owns the live display configuration: color1..color4 and misc.
- Queues register writes from the SPI receiver in a small FIFO.
- Applies queued writes only inside vertical blanking, so no mid-frame colour or mode change is ever visible.
- Sits between spi_receiver and the background/sprite/composition logic, replacing their ad-hoc next_frame gating.

---
 rtl/config_commit_scheduler_if.sv | 10 +
 rtl/config_commit_scheduler.sv | 139 +++++++++++++
 tb/tb_config_commit_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/config_commit_scheduler_if.sv
// Write port from spi_receiver into the config commit FIFO: valid/ready handshake with address and data.
interface config_commit_scheduler_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [5:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/config_commit_scheduler.sv
// Queues display config writes and applies them inside vblank; target register updates one edge after the pop.
// wr_ready = !full from a registered flag, writes while full set sticky overflow; LINE_COMMIT_EN adds hblank colour commits.
module config_commit_scheduler #(
  parameter int         DEPTH          = 4,
  parameter logic [5:0] COLOR1_DEFAULT = 6'b110001,
  parameter logic [5:0] COLOR2_DEFAULT = 6'b010101,
  parameter logic [5:0] COLOR3_DEFAULT = 6'b001100,
  parameter logic [5:0] COLOR4_DEFAULT = 6'b101100,
  parameter logic [4:0] MISC_DEFAULT   = 5'b00110
) (
  input  logic                       clk,
  input  logic                       reset,
  config_commit_scheduler_if.slave   wr,
  input  logic                       vblank,
  input  logic                       hblank,
  input  logic                       clear_ovf,
  output logic [5:0]                 color1,
  output logic [5:0]                 color2,
  output logic [5:0]                 color3,
  output logic [5:0]                 color4,
  output logic [4:0]                 misc,
  output logic                       commit_pulse,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [2:0] addr;
    logic [5:0] data;
  } entry_t;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t             state_q, state_d;
  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q, count_d, budget_q, budget_d;
  logic               full_q;
  logic               vblank_q, vblank_rise;
  logic               push, pop, drain_pop, line_pop;

  assign head        = mem[rd_ptr];
  assign wr.wr_ready = !full_q;
  assign push        = wr.wr_valid && wr.wr_ready;
  assign vblank_rise = vblank && !vblank_q;
  assign pop         = (drain_pop || line_pop) && (count_q != '0);
  assign count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
  assign pending     = count_q;

`ifdef LINE_COMMIT_EN
  // Only colour entries may slip in during hblank; a misc or reserved head waits for vblank.
  assign line_pop = hblank && !vblank && (head.addr < 3'd4);
`else
  logic unused_hblank;
  assign unused_hblank = hblank;
  assign line_pop      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_t'({wr.wr_addr, wr.wr_data});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      overflow <= 1'b0;
      vblank_q <= 1'b0;
      state_q  <= IDLE;
      budget_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      vblank_q <= vblank;
      state_q  <= state_d;
      budget_q <= budget_d;
      // A new overflow event outranks a simultaneous clear.
      if (wr.wr_valid && !wr.wr_ready) overflow <= 1'b1;
      else if (clear_ovf)              overflow <= 1'b0;
    end
  end

  // Budget is latched at the window start so entries pushed mid-window wait for the next frame.
  always_comb begin
    state_d   = state_q;
    budget_d  = budget_q;
    drain_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (vblank_rise && (count_q != '0)) begin
          state_d  = DRAIN;
          budget_d = count_q;
        end
      end
      DRAIN: begin
        if (!vblank || (budget_q == '0)) begin
          state_d = IDLE;
        end else begin
          drain_pop = 1'b1;
          budget_d  = budget_q - 1'b1;
          if (budget_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color1       <= COLOR1_DEFAULT;
      color2       <= COLOR2_DEFAULT;
      color3       <= COLOR3_DEFAULT;
      color4       <= COLOR4_DEFAULT;
      misc         <= MISC_DEFAULT;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= pop;
      if (pop) begin
        case (head.addr)
          3'd0:    color1 <= head.data;
          3'd1:    color2 <= head.data;
          3'd2:    color3 <= head.data;
          3'd3:    color4 <= head.data;
          3'd4:    misc   <= head.data[4:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_config_commit_scheduler.sv
// Directed self-checking bench for config_commit_scheduler; expected values are hand-computed per scenario.
module tb_config_commit_scheduler;
  logic       clk;
  logic       reset;
  logic       vblank, hblank, clear_ovf;
  logic [5:0] color1, color2, color3, color4;
  logic [4:0] misc;
  logic       commit_pulse;
  logic [2:0] pending;
  logic       overflow;
  int         checks;
  int         errors;

  config_commit_scheduler_if wr_if ();

  config_commit_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr_if),
    .vblank       (vblank),
    .hblank       (hblank),
    .clear_ovf    (clear_ovf),
    .color1       (color1),
    .color2       (color2),
    .color3       (color3),
    .color4       (color4),
    .misc         (misc),
    .commit_pulse (commit_pulse),
    .pending      (pending),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] addr, input logic [5:0] data);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = addr;
    wr_if.wr_data  = data;
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; vblank = 1'b0; hblank = 1'b0; clear_ovf = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (color1 !== 6'b110001) begin errors++; $display("FAIL reset_color1: got %b expected %b", color1, 6'b110001); end
    checks++; if (color2 !== 6'b010101) begin errors++; $display("FAIL reset_color2: got %b expected %b", color2, 6'b010101); end
    checks++; if (color3 !== 6'b001100) begin errors++; $display("FAIL reset_color3: got %b expected %b", color3, 6'b001100); end
    checks++; if (color4 !== 6'b101100) begin errors++; $display("FAIL reset_color4: got %b expected %b", color4, 6'b101100); end
    checks++; if (misc !== 5'b00110) begin errors++; $display("FAIL reset_misc: got %b expected %b", misc, 5'b00110); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", pending); end
    checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_if.wr_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL reset_commit_pulse: got %b expected 0", commit_pulse); end
  endtask

  task automatic test_single_commit();
    push(3'd1, 6'h3F);
    checks++; if (pending !== 3'd1) begin errors++; $display("FAIL single_pending_queued: got %0d expected 1", pending); end
    checks++; if (color2 !== 6'b010101) begin errors++; $display("FAIL single_color2_held: got %h expected %h", color2, 6'b010101); end
    vblank = 1'b1;
    tick();
    checks++; if (color2 !== 6'b010101) begin errors++; $display("FAIL single_color2_edge1: got %h expected %h", color2, 6'b010101); end
    tick();
    checks++; if (color2 !== 6'h3F) begin errors++; $display("FAIL single_color2_applied: got %h expected 3f", color2); end
    checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse: got %b expected 1", commit_pulse); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL single_pending_drained: got %0d expected 0", pending); end
    tick();
    checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_one_cycle: got %b expected 0", commit_pulse); end
    vblank = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    push(3'd0, 6'h0A); push(3'd1, 6'h0B); push(3'd2, 6'h0C); push(3'd3, 6'h0D);
    checks++; if (pending !== 3'd4) begin errors++; $display("FAIL full_pending: got %0d expected 4", pending); end
    checks++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b expected 0", wr_if.wr_ready); end
    push(3'd4, 6'h1F);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++; if (pending !== 3'd4) begin errors++; $display("FAIL ovf_dropped: got %0d expected 4", pending); end
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    clear_ovf = 1'b1; push(3'd4, 6'h1F); clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_clear_collision: got %b expected 1", overflow); end
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    vblank = 1'b1;
    tick();
    // First pop is in flight this cycle; ready must still be low.
    checks++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL ready_not_same_cycle_as_pop: got %b expected 0", wr_if.wr_ready); end
    tick();
    checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b expected 1", wr_if.wr_ready); end
    tick(); tick(); tick();
    checks++; if (color1 !== 6'h0A) begin errors++; $display("FAIL full_color1: got %h expected 0a", color1); end
    checks++; if (color2 !== 6'h0B) begin errors++; $display("FAIL full_color2: got %h expected 0b", color2); end
    checks++; if (color3 !== 6'h0C) begin errors++; $display("FAIL full_color3: got %h expected 0c", color3); end
    checks++; if (color4 !== 6'h0D) begin errors++; $display("FAIL full_color4: got %h expected 0d", color4); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d expected 0", pending); end
    checks++; if (misc !== 5'b00110) begin errors++; $display("FAIL full_misc_untouched: got %b expected 00110", misc); end
    vblank = 1'b0;
    tick();
  endtask

  task automatic test_partial_drain();
    push(3'd0, 6'h11); push(3'd1, 6'h12); push(3'd2, 6'h13);
    vblank = 1'b1;
    tick();
    tick();
    vblank = 1'b0;
    tick();
    checks++; if (color1 !== 6'h11) begin errors++; $display("FAIL partial_color1: got %h expected 11", color1); end
    checks++; if (color2 !== 6'h0B) begin errors++; $display("FAIL partial_color2_held: got %h expected 0b", color2); end
    checks++; if (pending !== 3'd2) begin errors++; $display("FAIL partial_pending: got %0d expected 2", pending); end
    checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL partial_no_pulse: got %b expected 0", commit_pulse); end
    tick();
    vblank = 1'b1;
    tick(); tick();
    checks++; if (color2 !== 6'h12) begin errors++; $display("FAIL partial_color2_next: got %h expected 12", color2); end
    checks++; if (color3 !== 6'h0C) begin errors++; $display("FAIL partial_color3_order: got %h expected 0c", color3); end
    tick();
    checks++; if (color3 !== 6'h13) begin errors++; $display("FAIL partial_color3_next: got %h expected 13", color3); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL partial_empty: got %0d expected 0", pending); end
    vblank = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    push(3'd0, 6'h01); push(3'd0, 6'h02);
    vblank = 1'b1;
    tick();
    // Push lands in the same cycle as the first pop.
    push(3'd3, 6'h2A);
    checks++; if (color1 !== 6'h01) begin errors++; $display("FAIL b2b_color1_first: got %h expected 01", color1); end
    checks++; if (pending !== 3'd2) begin errors++; $display("FAIL b2b_push_pop_pending: got %0d expected 2", pending); end
    tick();
    checks++; if (color1 !== 6'h02) begin errors++; $display("FAIL b2b_last_wins: got %h expected 02", color1); end
    checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL b2b_second_pulse: got %b expected 1", commit_pulse); end
    tick(); tick();
    checks++; if (color4 !== 6'h0D) begin errors++; $display("FAIL b2b_window_push_held: got %h expected 0d", color4); end
    checks++; if (pending !== 3'd1) begin errors++; $display("FAIL b2b_pending_held: got %0d expected 1", pending); end
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    tick(); tick();
    checks++; if (color4 !== 6'h2A) begin errors++; $display("FAIL b2b_next_frame: got %h expected 2a", color4); end
    vblank = 1'b0;
    tick();
  endtask

  task automatic test_reserved_and_misc();
    push(3'd6, 6'h3F); push(3'd4, 6'h3F); push(3'd2, 6'h05);
    vblank = 1'b1;
    tick(); tick();
    checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL reserved_pulse: got %b expected 1", commit_pulse); end
    checks++; if ({color1, color2, color3, color4, misc} !== {6'h02, 6'h12, 6'h13, 6'h2A, 5'b00110}) begin errors++; $display("FAIL reserved_no_write: got %h %h %h %h %h expected 02 12 13 2a 06", color1, color2, color3, color4, misc); end
    checks++; if (pending !== 3'd2) begin errors++; $display("FAIL reserved_consumes: got %0d expected 2", pending); end
    tick();
    checks++; if (misc !== 5'h1F) begin errors++; $display("FAIL misc_write: got %h expected 1f", misc); end
    tick();
    checks++; if (color3 !== 6'h05) begin errors++; $display("FAIL reserved_then_color3: got %h expected 05", color3); end
    vblank = 1'b0;
    tick();
  endtask

  task automatic test_hblank();
`ifdef LINE_COMMIT_EN
    push(3'd3, 6'h15);
    hblank = 1'b1; tick(); hblank = 1'b0;
    checks++; if (color4 !== 6'h15) begin errors++; $display("FAIL line_commit_color: got %h expected 15", color4); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL line_commit_pending: got %0d expected 0", pending); end
    push(3'd4, 6'h01); push(3'd3, 6'h16);
    hblank = 1'b1; tick(); tick(); hblank = 1'b0;
    checks++; if (misc !== 5'h1F || color4 !== 6'h15) begin errors++; $display("FAIL line_misc_blocks: got %h %h expected 1f 15", misc, color4); end
    checks++; if (pending !== 3'd2) begin errors++; $display("FAIL line_blocked_pending: got %0d expected 2", pending); end
    vblank = 1'b1;
    tick(); tick();
    checks++; if (misc !== 5'h01) begin errors++; $display("FAIL line_misc_vblank: got %h expected 01", misc); end
    tick();
    checks++; if (color4 !== 6'h16) begin errors++; $display("FAIL line_color_after_misc: got %h expected 16", color4); end
`else
    push(3'd3, 6'h15);
    hblank = 1'b1; tick(); tick(); hblank = 1'b0;
    checks++; if (color4 !== 6'h2A) begin errors++; $display("FAIL hblank_ignored: got %h expected 2a", color4); end
    checks++; if (pending !== 3'd1) begin errors++; $display("FAIL hblank_pending: got %0d expected 1", pending); end
    vblank = 1'b1;
    tick(); tick();
    checks++; if (color4 !== 6'h15) begin errors++; $display("FAIL hblank_vblank_commit: got %h expected 15", color4); end
`endif
    vblank = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    push(3'd0, 6'h33); push(3'd1, 6'h34);
    reset = 1'b1;
    #1;
    checks++; if (color1 !== 6'b110001) begin errors++; $display("FAIL async_reset_color1: got %b expected 110001", color1); end
    checks++; if (color4 !== 6'b101100) begin errors++; $display("FAIL async_reset_color4: got %b expected 101100", color4); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL async_reset_pending: got %0d expected 0", pending); end
    tick();
    reset = 1'b0;
    tick();
    vblank = 1'b1;
    tick(); tick(); tick();
    checks++; if (color1 !== 6'b110001 || color2 !== 6'b010101) begin errors++; $display("FAIL reset_discards_queue: got %h %h expected 31 15", color1, color2); end
    checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL reset_no_pulse: got %b expected 0", commit_pulse); end
    vblank = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_commit();
    test_overflow();
    test_partial_drain();
    test_back_to_back();
    test_reserved_and_misc();
    test_hblank();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
